// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// data (load/store) port. One transaction is in flight at a time:
//   IDLE -> ISSUE (strobe held until MemWaitreq=0) -> WAIT (reads only) -> RESP.
// The RESP cycle is the only cycle in which the owning port sees waitreq=0.
//
// Parameters:
//   WORD_SIZE    address/data width
//   MEM_LATENCY  cycles from read accept to valid MemReadData (>=1)
//   STARVE_LIMIT lost arbitrations before the fetch port is forced to win (>=1)
//
// Ports:
//   Clock, Resetn                   clock, asynchronous active-low reset
//   InstrReq/InstrAddr              fetch request and address
//   InstrIn/InstrWaitreq            fetched word, fetch-not-complete flag
//   ReadData/WriteData              data read / write request (write wins if both)
//   DataAddr/DataOut                data address and store data
//   DataIn/DataWaitreq              load word, data-not-complete flag
//   MemAddr/MemRead/MemWrite        memory address and strobes
//   MemWriteData/MemReadData        memory write / read data
//   MemWaitreq                      memory not accepting this cycle
//
// Build option: define MEM_PORT_ARB_RR_EN to replace data-priority with
// starvation guard by strict round-robin between the two ports.

module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 InstrReq,
   input  logic [WORD_SIZE-1:0] InstrAddr,
   output logic [WORD_SIZE-1:0] InstrIn,
   output logic                 InstrWaitreq,
   input  logic                 ReadData,
   input  logic                 WriteData,
   input  logic [WORD_SIZE-1:0] DataAddr,
   input  logic [WORD_SIZE-1:0] DataOut,
   output logic [WORD_SIZE-1:0] DataIn,
   output logic                 DataWaitreq,
   output logic [WORD_SIZE-1:0] MemAddr,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [WORD_SIZE-1:0] MemWriteData,
   input  logic [WORD_SIZE-1:0] MemReadData,
   input  logic                 MemWaitreq
);

   localparam int unsigned LatW = $clog2(MEM_LATENCY + 1);
   localparam logic [LatW-1:0] LatLoad = LatW'(MEM_LATENCY);
   localparam logic [LatW-1:0] LatOne  = LatW'(1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e state_q, state_d;

   logic                 owner_data_q, owner_data_d;   // 1 = data port owns the transaction
   logic                 op_write_q, op_write_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
   logic [WORD_SIZE-1:0] instr_in_q, instr_in_d;
   logic [WORD_SIZE-1:0] data_in_q, data_in_d;

   logic data_req;
   logic any_req;
   logic grant_data;

   assign data_req = ReadData | WriteData;
   assign any_req  = InstrReq | data_req;

`ifdef MEM_PORT_ARB_RR_EN
   // Last winner of a contested arbitration; resets to fetch so data wins first.
   logic last_win_instr_q, last_win_instr_d;

   always_comb begin
      grant_data       = data_req;
      last_win_instr_d = last_win_instr_q;
      if (InstrReq && data_req) begin
         grant_data = last_win_instr_q;
         if (state_q == StIdle) begin
            last_win_instr_d = ~last_win_instr_q;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         last_win_instr_q <= 1'b1;
      end else begin
         last_win_instr_q <= last_win_instr_d;
      end
   end
`else
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

   // Data has priority unless fetch has lost STARVE_LIMIT times in a row.
   always_comb begin
      grant_data   = data_req && !(InstrReq && (starve_cnt_q == StarveMax));
      starve_cnt_d = starve_cnt_q;
      if ((state_q == StIdle) && InstrReq) begin
         if (grant_data) begin
            if (starve_cnt_q != StarveMax) begin
               starve_cnt_d = starve_cnt_q + StarveW'(1);
            end
         end else begin
            starve_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`endif

   // State register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!MemWaitreq) begin
               state_d = op_write_q ? StResp : StWait;
            end
         end
         StWait: begin
            if (lat_cnt_q == LatOne) begin
               state_d = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Transaction latches, latency counter and read capture
   always_comb begin
      owner_data_d = owner_data_q;
      op_write_d   = op_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_cnt_d    = lat_cnt_q;
      instr_in_d   = instr_in_q;
      data_in_d    = data_in_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               owner_data_d = grant_data;
               op_write_d   = grant_data & WriteData;
               addr_d       = grant_data ? DataAddr : InstrAddr;
               if (grant_data && WriteData) begin
                  wdata_d = DataOut;
               end
            end
         end
         StIssue: begin
            if (!MemWaitreq && !op_write_q) begin
               lat_cnt_d = LatLoad;
            end
         end
         StWait: begin
            lat_cnt_d = lat_cnt_q - LatOne;
            // Captured even if the requester has since dropped its request.
            if (lat_cnt_q == LatOne) begin
               if (owner_data_q) begin
                  data_in_d = MemReadData;
               end else begin
                  instr_in_d = MemReadData;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         owner_data_q <= 1'b0;
         op_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_cnt_q    <= '0;
         instr_in_q   <= '0;
         data_in_q    <= '0;
      end else begin
         owner_data_q <= owner_data_d;
         op_write_q   <= op_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_cnt_q    <= lat_cnt_d;
         instr_in_q   <= instr_in_d;
         data_in_q    <= data_in_d;
      end
   end

   // Outputs
   always_comb begin
      MemRead      = (state_q == StIssue) && !op_write_q;
      MemWrite     = (state_q == StIssue) && op_write_q;
      MemAddr      = addr_q;
      MemWriteData = wdata_q;
      InstrIn      = instr_in_q;
      DataIn       = data_in_q;
      InstrWaitreq = InstrReq && !((state_q == StResp) && !owner_data_q);
      DataWaitreq  = data_req && !((state_q == StResp) && owner_data_q);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance with a behavioural memory
// (write log over a fixed init pattern, programmable accept stall) and a
// latency-3 instance driven by hand for the read-latency corner case.

module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;

   logic        instr_req;
   logic [15:0] instr_addr;
   logic [15:0] instr_in;
   logic        instr_waitreq;
   logic        read_data;
   logic        write_data;
   logic [15:0] data_addr;
   logic [15:0] data_out;
   logic [15:0] data_in;
   logic        data_waitreq;
   logic [15:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_waitreq;

   logic        l3_instr_req;
   logic [15:0] l3_instr_addr;
   logic [15:0] l3_instr_in;
   logic        l3_instr_waitreq;
   logic        l3_read_data;
   logic        l3_write_data;
   logic [15:0] l3_data_addr;
   logic [15:0] l3_data_out;
   logic [15:0] l3_data_in;
   logic        l3_data_waitreq;
   logic [15:0] l3_mem_addr;
   logic        l3_mem_read;
   logic        l3_mem_write;
   logic [15:0] l3_mem_wdata;
   logic [15:0] l3_mem_rdata;
   logic        l3_mem_waitreq;

   mem_port_arbiter #(
      .WORD_SIZE   (16),
      .MEM_LATENCY (1),
      .STARVE_LIMIT(4)
   ) u_dut (
      .Clock       (clk),
      .Resetn      (rst_n),
      .InstrReq    (instr_req),
      .InstrAddr   (instr_addr),
      .InstrIn     (instr_in),
      .InstrWaitreq(instr_waitreq),
      .ReadData    (read_data),
      .WriteData   (write_data),
      .DataAddr    (data_addr),
      .DataOut     (data_out),
      .DataIn      (data_in),
      .DataWaitreq (data_waitreq),
      .MemAddr     (mem_addr),
      .MemRead     (mem_read),
      .MemWrite    (mem_write),
      .MemWriteData(mem_wdata),
      .MemReadData (mem_rdata),
      .MemWaitreq  (mem_waitreq)
   );

   mem_port_arbiter #(
      .WORD_SIZE   (16),
      .MEM_LATENCY (3),
      .STARVE_LIMIT(4)
   ) u_dut_lat3 (
      .Clock       (clk),
      .Resetn      (rst_n),
      .InstrReq    (l3_instr_req),
      .InstrAddr   (l3_instr_addr),
      .InstrIn     (l3_instr_in),
      .InstrWaitreq(l3_instr_waitreq),
      .ReadData    (l3_read_data),
      .WriteData   (l3_write_data),
      .DataAddr    (l3_data_addr),
      .DataOut     (l3_data_out),
      .DataIn      (l3_data_in),
      .DataWaitreq (l3_data_waitreq),
      .MemAddr     (l3_mem_addr),
      .MemRead     (l3_mem_read),
      .MemWrite    (l3_mem_write),
      .MemWriteData(l3_mem_wdata),
      .MemReadData (l3_mem_rdata),
      .MemWaitreq  (l3_mem_waitreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory model for the latency-1 instance ----------------
   logic [15:0] wr_mem [256];
   bit          wr_vld [256];
   logic        rd_valid;
   logic [7:0]  rd_addr;
   int          stall_seen;
   int          stall_cfg;

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 16'hA5A5 : {8'h5A, a};
   endfunction

   always @(posedge clk) begin
      if (mem_write && !mem_waitreq) begin
         wr_mem[mem_addr[7:0]] <= mem_wdata;
         wr_vld[mem_addr[7:0]] <= 1'b1;
      end
      rd_valid <= mem_read && !mem_waitreq;
      rd_addr  <= mem_addr[7:0];
      if (mem_read || mem_write) begin
         if (mem_waitreq) stall_seen <= stall_seen + 1;
      end else begin
         stall_seen <= 0;
      end
   end

   always_comb begin
      mem_waitreq = (mem_read || mem_write) && (stall_seen < stall_cfg);
      mem_rdata   = 16'hDEAD;
      if (rd_valid) begin
         mem_rdata = wr_vld[rd_addr] ? wr_mem[rd_addr] : init_val(rd_addr);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_instr;
      logic        is_write;
      logic        both;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          stall;
      logic [15:0] exp_data;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      int          k;
   } exp_t;

   exp_t        exp_q[$];
   logic        grant_q[$];   // 1 = data port
   logic [15:0] model_instr_in;
   logic [15:0] model_data_in;
   vec_t        vecs [7];

   // Runs one single-port transaction; k counts falling edges from the drive cycle.
   task automatic run_txn(input string name, input vec_t v);
      exp_t       e;
      bit         done;
      bit         strobe_ok;
      bit         exp_strobe;
      logic [1:0] exp_rw;
      logic       wr;
      @(posedge clk); #1;
      stall_cfg = v.stall;
      if (v.is_instr) begin
         instr_req  = 1'b1;
         instr_addr = v.addr;
      end else begin
         read_data  = !v.is_write || v.both;
         write_data = v.is_write;
         data_addr  = v.addr;
         data_out   = v.wdata;
      end
      e.data = v.is_write ? model_data_in : v.exp_data;
      e.k    = v.is_write ? 2 + v.stall : 3 + v.stall;
      exp_q.push_back(e);
      exp_rw    = v.is_write ? 2'b01 : 2'b10;
      done      = 1'b0;
      strobe_ok = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         exp_strobe = (k >= 1) && (k <= 1 + v.stall);
         if ({mem_read, mem_write} != (exp_strobe ? exp_rw : 2'b00)) strobe_ok = 1'b0;
         if (exp_strobe && (mem_addr != v.addr)) strobe_ok = 1'b0;
         if (exp_strobe && v.is_write && (mem_wdata != v.wdata)) strobe_ok = 1'b0;
         wr = v.is_instr ? instr_waitreq : data_waitreq;
         if (!wr) begin
            done = 1'b1;
            e    = exp_q.pop_front();
            check({name, "_latency"}, k, e.k);
            check({name, "_rdata"}, v.is_instr ? instr_in : data_in, e.data);
         end
      end
      check({name, "_done"}, done, 1);
      if (!done) exp_q.delete();
      check({name, "_strobes"}, strobe_ok, 1);
      check({name, "_other_hold"}, v.is_instr ? data_in : instr_in,
            v.is_instr ? model_data_in : model_instr_in);
      if (!v.is_write) begin
         if (v.is_instr) model_instr_in = v.exp_data;
         else model_data_in = v.exp_data;
      end
      @(posedge clk); #1;
      instr_req  = 1'b0;
      read_data  = 1'b0;
      write_data = 1'b0;
      stall_cfg  = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   n_grants;
      logic got;
      logic exp_g;

      rst_n = 1'b0;
      instr_req = 1'b0; instr_addr = '0; read_data = 1'b0; write_data = 1'b0;
      data_addr = '0; data_out = '0; stall_cfg = 0;
      l3_instr_req = 1'b0; l3_instr_addr = '0; l3_read_data = 1'b0; l3_write_data = 1'b0;
      l3_data_addr = '0; l3_data_out = '0; l3_mem_rdata = 16'hDEAD; l3_mem_waitreq = 1'b0;
      model_instr_in = '0;
      model_data_in  = '0;

      vecs[0] = '{is_instr:1'b1, is_write:1'b0, both:1'b0, addr:16'h0010, wdata:16'h0000,
                  stall:0, exp_data:16'hA5A5};
      vecs[1] = '{is_instr:1'b0, is_write:1'b1, both:1'b0, addr:16'h0200, wdata:16'h1234,
                  stall:3, exp_data:16'h0000};
      vecs[2] = '{is_instr:1'b0, is_write:1'b0, both:1'b0, addr:16'h0200, wdata:16'h0000,
                  stall:0, exp_data:16'h1234};
      vecs[3] = '{is_instr:1'b0, is_write:1'b1, both:1'b1, addr:16'h0044, wdata:16'hBEEF,
                  stall:1, exp_data:16'h0000};
      vecs[4] = '{is_instr:1'b1, is_write:1'b0, both:1'b0, addr:16'h0044, wdata:16'h0000,
                  stall:2, exp_data:16'hBEEF};
      vecs[5] = '{is_instr:1'b0, is_write:1'b0, both:1'b0, addr:16'h0011, wdata:16'h0000,
                  stall:0, exp_data:16'h5A11};
      vecs[6] = '{is_instr:1'b1, is_write:1'b0, both:1'b0, addr:16'h00FF, wdata:16'h0000,
                  stall:1, exp_data:16'h5AFF};

      // Reset state
      #12;
      check("rst_strobes", {mem_read, mem_write}, 2'b00);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 16'h0000);
      check("rst_instr_in", instr_in, 16'h0000);
      check("rst_data_in", data_in, 16'h0000);
      instr_req = 1'b1;
      #1 check("rst_instr_waitreq", instr_waitreq, 1'b1);
      instr_req = 1'b0;
      #1 check("rst_instr_waitreq_idle", instr_waitreq, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-port transactions
      for (int i = 0; i < 7; i++) begin
         run_txn($sformatf("vec%0d", i), vecs[i]);
      end

      // Both ports held: grant order
`ifdef MEM_PORT_ARB_RR_EN
      for (int i = 0; i < 10; i++) grant_q.push_back((i % 2) == 0);
`else
      for (int i = 0; i < 10; i++) grant_q.push_back((i % 5) != 4);
`endif
      @(posedge clk); #1;
      instr_req = 1'b1; instr_addr = 16'h0010;
      read_data = 1'b1; data_addr = 16'h0011;
      n_grants = 0;
      for (int k = 0; k < 80 && n_grants < 10; k++) begin
         @(negedge clk);
         if (!instr_waitreq || !data_waitreq) begin
            got   = instr_waitreq;
            exp_g = grant_q.pop_front();
            check($sformatf("arb_grant%0d", n_grants), got, exp_g);
            check($sformatf("arb_rdata%0d", n_grants), got ? data_in : instr_in,
                  got ? 16'h5A11 : 16'hA5A5);
            n_grants++;
         end
      end
      check("arb_grant_count", n_grants, 10);
      grant_q.delete();
      @(posedge clk); #1;
      instr_req = 1'b0; read_data = 1'b0;
      model_instr_in = 16'hA5A5;
      model_data_in  = 16'h5A11;

      // Abandoned fetch with a data read queued behind it
      @(posedge clk); #1;
      instr_req = 1'b1; instr_addr = 16'h0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      instr_req = 1'b0;
      read_data = 1'b1; data_addr = 16'h0022;
      for (int k = 2; k <= 7; k++) begin
         @(negedge clk);
         check($sformatf("abn_data_waitreq_k%0d", k), data_waitreq, k != 7);
         check($sformatf("abn_mem_read_k%0d", k), mem_read, k == 5);
         if (k == 5) check("abn_mem_addr", mem_addr, 16'h0022);
         if (k == 7) check("abn_data_in", data_in, 16'h5A22);
      end
      @(posedge clk); #1;
      read_data = 1'b0;
      model_data_in = 16'h5A22;

      // Latency-3 instance: read accepted at t+1, data valid at t+4, RESP at t+5
      @(posedge clk); #1;
      l3_read_data = 1'b1; l3_data_addr = 16'h0003;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            l3_mem_rdata = (k == 4) ? 16'h0BEE : 16'hDEAD;
         end
         @(negedge clk);
         check($sformatf("lat3_waitreq_k%0d", k), l3_data_waitreq, k != 5);
         check($sformatf("lat3_mem_read_k%0d", k), l3_mem_read, k == 1);
         if (k == 1) check("lat3_mem_addr", l3_mem_addr, 16'h0003);
         if (k == 5) check("lat3_data_in", l3_data_in, 16'h0BEE);
      end
      @(posedge clk); #1;
      l3_read_data = 1'b0;

      // Reset while a fetch is in WAIT
      @(posedge clk); #1;
      instr_req = 1'b1; instr_addr = 16'h0010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mrst_strobes", {mem_read, mem_write}, 2'b00);
      check("mrst_mem_addr", mem_addr, 16'h0000);
      check("mrst_mem_wdata", mem_wdata, 16'h0000);
      check("mrst_instr_in", instr_in, 16'h0000);
      check("mrst_data_in", data_in, 16'h0000);
      check("mrst_instr_waitreq", instr_waitreq, 1'b1);
      @(negedge clk);
      check("mrst_held_strobes", {mem_read, mem_write}, 2'b00);
      instr_req = 1'b0;
      #1 rst_n = 1'b1;
      model_instr_in = '0;
      model_data_in  = '0;
      v = vecs[0];
      run_txn("post_rst_read", v);
      v = '{is_instr:1'b0, is_write:1'b1, both:1'b0, addr:16'h0030, wdata:16'h7777,
            stall:0, exp_data:16'h0000};
      run_txn("post_rst_write", v);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
